barcode_serializer: RTL and testbench
=====================================

# barcode_serializer

Bit-serial source for the barcode filter path: accepts 8-bit barcode words over a valid/ready handshake, buffers them, and replays each word LSB-first as a 1-bit `signal` with a one-cycle `sample` strobe per bit. It is the transmit end of the `sample`/`signal` interface consumed by the FIR stage. It drives the filter from stored patterns for bench and on-board replay, with no photodiode front end.

## Interface

- `DIV`, 4: clock cycles per serialized bit; legal range 1..65535.
- `DEPTH`, 4: input FIFO entries; power of two, at least 2. Used only when the FIFO is compiled in.

- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  barcode word; bit 0 is sent first.
- `in_valid`  in  1  `in_data` is presented.
- `in_ready`  out  1  buffer can accept a word this cycle.
- `signal`  out  1  current serialized bit; this is the filter's `signal` input.
- `sample`  out  1  one-cycle strobe marking `signal` as valid; this is the filter's `sample` input.
- `busy`  out  1  a word is shifting or the buffer is non-empty.

## Operation

- Push: occurs on any edge where `in_valid && in_ready`.
  - `in_ready = !full`. The full flag comes from registered pointers.
  - When full, `in_ready` stays low even if a pop occurs in the same cycle.
  - A word presented while `in_ready` is low is ignored. The source must hold it.
- FSM has 2 states: IDLE and SHIFT. Registers: `shreg[7:0]`, `bit_cnt[2:0]`, `div_cnt` (16 bits).
- IDLE:
  - `signal=0`, `sample=0`.
  - If the buffer is non-empty: pop the head into `shreg`, clear `bit_cnt` and `div_cnt`, go to SHIFT.
- SHIFT:
  - `signal = shreg[0]`, held stable for the whole bit window.
  - `div_cnt` counts 0..DIV-1.
  - `sample = (state==SHIFT && div_cnt==DIV-1)`, decoded from registers only.
  - On the edge ending a sample cycle:
    - If `bit_cnt != 7`: shift `shreg` right, increment `bit_cnt`, clear `div_cnt`.
    - If `bit_cnt == 7` and the buffer is non-empty: pop the next word into `shreg`, clear the counters, stay in SHIFT. There are no gap cycles between words.
    - If `bit_cnt == 7` and the buffer is empty: return to IDLE.
- A push and a pop on the same edge are both honoured when not full. A push into an empty buffer in the same edge that SHIFT finds it empty is not popped; it is popped by IDLE on the next edge.
- `busy = (state==SHIFT) || !empty`.
- `DIV=1`: `sample` stays high every SHIFT cycle and the bit changes every cycle.

## Timing

- Reset values:
  - `signal=0`, `sample=0`, `busy=0`, `in_ready=1`.
  - FSM in IDLE, buffer empty, `shreg`, `bit_cnt` and `div_cnt` all 0.
- Reset asserted mid-word discards the in-flight word and all buffered words. Outputs take their reset values on the next edge.
- Latency from a push at edge N into an idle, empty block:
  - SHIFT is entered at edge N+1, and `signal` shows bit 0 from that edge.
  - The first `sample` is high in the cycle following edge N+DIV.
- Each word takes exactly 8*DIV cycles. A continuously fed buffer produces a gap-free stream of 8 strobes per word.
- The consumer samples `signal` on the rising edge that ends a `sample`-high cycle. `signal` does not change until after that edge.

## Configuration

- `BARCODE_SER_FIFO_EN`:
  - Defined: the buffer is a DEPTH-entry circular FIFO with wrap-around pointers and an extra occupancy bit for the full/empty decision.
  - Undefined: the buffer is a single holding register and DEPTH is ignored. `in_ready` is low while the register is occupied; it rises on the edge that pops into `shreg`.
- The serialization timing, handshake rules and reset behaviour are identical in both builds.

## Test plan

- Byte order: DIV=1, push 8'b10010110 into an idle block. `signal` at the 8 strobes reads 0,1,1,0,1,0,0,1. `busy` falls 9 cycles after the push.
- Latency and rate: DIV=4, push 8'hFF at edge N. The first `sample` is in the cycle after edge N+4, strobes are spaced exactly 4 cycles apart, there are 8 strobes total, and `signal` holds steady between strobes.
- Back-to-back stream: DIV=2, push 8'h00, 8'hFF, 8'hA5 consecutively. 24 strobes with no gap, bit values 0×8, then 1×8, then 1,0,1,0,0,1,0,1.
- Backpressure and full:
  - FIFO build with DEPTH=4 and DIV=8: hold `in_valid` high for 6 words. The first is popped into `shreg` and 4 fill the FIFO, then `in_ready` drops.
  - The sixth word is accepted only after the next pop, and all 6 words are emitted in order.
  - No-FIFO build: `in_ready` alternates per word.
- Reset mid-word: DIV=3, reset asserted after the 4th strobe of a word with 2 words buffered. The next edge gives `signal=0`, `sample=0`, `busy=0`, `in_ready=1`, and no further strobes occur.
- Pointer wrap: FIFO build with DEPTH=4, DIV=1, stream 11 words with single-cycle `in_valid` gaps. All 88 bits match the pushed data after the pointers wrap twice.

Source files
------------

// File: rtl/barcode_serializer.sv
// Buffered LSB-first bit serializer driving the FIR stage sample/signal interface.
// Define BARCODE_SER_FIFO_EN for a DEPTH-entry FIFO; otherwise a single holding register buffers input.
module barcode_serializer #(
    parameter int unsigned DIV   = 4,
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       signal,
    output logic       sample,
    output logic       busy
);

    if (DIV < 1 || DIV > 65535) begin : g_bad_div
        $error("barcode_serializer: DIV out of range 1..65535");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("barcode_serializer: DEPTH must be a power of two >= 2");
    end

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    typedef enum logic {S_IDLE, S_SHIFT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  shreg_q, shreg_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [15:0] div_cnt_q, div_cnt_d;

    logic       full, empty, push, pop;
    logic [7:0] head;

    assign push     = in_valid && !full;
    assign in_ready = !full;

`ifdef BARCODE_SER_FIFO_EN
    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so equal indices can be told apart as full or empty.
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_data;
        end
    end
`else
    logic [7:0] hold_q, hold_d;
    logic       hold_vld_q, hold_vld_d;

    assign empty = !hold_vld_q;
    assign full  = hold_vld_q;
    assign head  = hold_q;

    // Push is only possible while empty and pop only while occupied, so they never coincide.
    always_comb begin
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        if (push) begin
            hold_d     = in_data;
            hold_vld_d = 1'b1;
        end else if (pop) begin
            hold_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
        end else begin
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
        end
    end
`endif

    assign sample = (state_q == S_SHIFT) && (div_cnt_q == DIV_LAST);
    assign signal = (state_q == S_SHIFT) && shreg_q[0];
    assign busy   = (state_q == S_SHIFT) || !empty;

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        div_cnt_d = div_cnt_q;
        pop       = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    shreg_d   = head;
                    bit_cnt_d = '0;
                    div_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (bit_cnt_q != 3'd7) begin
                        shreg_d   = {1'b0, shreg_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end else if (!empty) begin
                        pop       = 1'b1;
                        shreg_d   = head;
                        bit_cnt_d = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            div_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: tb/tb_barcode_serializer.sv
// Directed bench for barcode_serializer: five instances at DIV = 1,2,3,4,8, one observed at a time.
module tb_barcode_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din [5];
    logic [4:0] vld = '0;
    logic [4:0] rdy, sig_w, smp, bsy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int sel   = 0;

    bit  sbits[$];
    int  scyc[$];
    int  bfall[$];
    int  sig_changes = 0;
    logic bsy_prev = 1'b0;
    logic sig_prev = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 5; g++) begin : g_dut
        barcode_serializer #(
            .DIV  (g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 3 : g == 3 ? 4 : 8),
            .DEPTH(4)
        ) u_dut (
            .clk     (clk),
            .reset   (reset),
            .in_data (din[g]),
            .in_valid(vld[g]),
            .in_ready(rdy[g]),
            .signal  (sig_w[g]),
            .sample  (smp[g]),
            .busy    (bsy[g])
        );
    end

    always @(negedge clk) begin
        if (smp[sel]) begin
            sbits.push_back(sig_w[sel]);
            scyc.push_back(cyc);
        end
        if (bsy_prev && !bsy[sel]) bfall.push_back(cyc);
        bsy_prev = bsy[sel];
        if (sig_w[sel] != sig_prev) sig_changes++;
        sig_prev = sig_w[sel];
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
    endtask

    task automatic push(input int k, input logic [7:0] d, output int at);
        logic r;
        at     = -1;
        din[k] = d;
        vld[k] = 1'b1;
        for (int t = 0; t < 1000; t++) begin
            r = rdy[k];
            @(posedge clk);
            #1;
            if (r) begin
                at = cyc;
                break;
            end
        end
        vld[k] = 1'b0;
        if (at < 0) check("push_timeout", 0, 1);
    endtask

    task automatic wait_strobes(input int base, input int n, input int budget);
        for (int t = 0; t < budget && (sbits.size() - base) < n; t++) tick(1);
    endtask

    function automatic int got_byte(input int base, input int w);
        int v = 0;
        for (int b = 0; b < 8; b++) if (sbits[base + w*8 + b]) v |= (1 << b);
        return v;
    endfunction

    function automatic int spacing_errs(input int base, input int n, input int div);
        int e = 0;
        for (int i = 1; i < n; i++) if (scyc[base + i] - scyc[base + i - 1] != div) e++;
        return e;
    endfunction

    initial begin
        int n, base, bfb, chg0, cnt0;
        int acc[6];
        logic [7:0] w6 [6];
        logic [7:0] w11 [11];

        for (int k = 0; k < 5; k++) din[k] = '0;
        do_reset();
        check("rst_signal", int'(sig_w), 0);
        check("rst_sample", int'(smp), 0);
        check("rst_busy", int'(bsy), 0);
        check("rst_ready", int'(rdy), 31);

        // byte order, DIV=1
        sel = 0; tick(1);
        base = sbits.size(); bfb = bfall.size();
        push(0, 8'b10010110, n);
        wait_strobes(base, 8, 40);
        tick(4);
        check("t1_count", sbits.size() - base, 8);
        check("t1_byte", got_byte(base, 0), 8'h96);
        check("t1_first", scyc[base] - n, 1);
        check("t1_busy_falls", bfall.size() - bfb, 1);
        if (bfall.size() > bfb) check("t1_busy_lat", bfall[bfb] - n, 9);

        // latency and rate, DIV=4
        sel = 3; tick(1);
        base = sbits.size(); chg0 = sig_changes;
        push(3, 8'hFF, n);
        wait_strobes(base, 8, 100);
        tick(8);
        check("t2_count", sbits.size() - base, 8);
        check("t2_byte", got_byte(base, 0), 8'hFF);
        check("t2_first", scyc[base] - n, 4);
        check("t2_spacing", spacing_errs(base, 8, 4), 0);
        check("t2_sig_changes", sig_changes - chg0, 2);

        // back-to-back stream, DIV=2
        sel = 1; tick(1);
        base = sbits.size();
        push(1, 8'h00, n);
        push(1, 8'hFF, n);
        push(1, 8'hA5, n);
        wait_strobes(base, 24, 200);
        tick(4);
        check("t3_count", sbits.size() - base, 24);
        check("t3_spacing", spacing_errs(base, 24, 2), 0);
        check("t3_w0", got_byte(base, 0), 8'h00);
        check("t3_w1", got_byte(base, 1), 8'hFF);
        check("t3_w2", got_byte(base, 2), 8'hA5);

        // backpressure, DIV=8
        sel = 4; tick(1);
        base = sbits.size();
        w6 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int i = 0; i < 6; i++) begin
            push(4, w6[i], acc[i]);
`ifdef BARCODE_SER_FIFO_EN
            if (i == 4) check("t4_ready_low_full", int'(rdy[4]), 0);
`else
            check($sformatf("t4_ready_low_w%0d", i), int'(rdy[4]), 0);
`endif
        end
`ifdef BARCODE_SER_FIFO_EN
        check("t4_acc4", acc[4] - acc[0], 4);
        check("t4_acc5", acc[5] - acc[0], 66);
`else
        check("t4_acc1", acc[1] - acc[0], 2);
        check("t4_acc2", acc[2] - acc[1], 64);
`endif
        wait_strobes(base, 48, 800);
        tick(10);
        check("t4_count", sbits.size() - base, 48);
        for (int i = 0; i < 6; i++)
            if (sbits.size() - base >= 48)
                check($sformatf("t4_w%0d", i), got_byte(base, i), int'(w6[i]));

        // reset mid-word, DIV=3
        sel = 2; tick(1);
        base = sbits.size();
        push(2, 8'h3C, n);
        push(2, 8'hC3, n);
`ifdef BARCODE_SER_FIFO_EN
        push(2, 8'h5A, n);
`endif
        wait_strobes(base, 4, 100);
        check("t5_reached4", sbits.size() - base, 4);
        reset = 1'b1;
        tick(1);
        check("t5_signal", int'(sig_w[2]), 0);
        check("t5_sample", int'(smp[2]), 0);
        check("t5_busy", int'(bsy[2]), 0);
        check("t5_ready", int'(rdy[2]), 1);
        reset = 1'b0;
        cnt0 = sbits.size();
        tick(80);
        check("t5_no_strobes", sbits.size() - cnt0, 0);

        // pointer wrap, DIV=1, one idle cycle between words
        sel = 0; tick(1);
        base = sbits.size();
        for (int i = 0; i < 11; i++) begin
            w11[i] = 8'(i * 37 + 5);
            push(0, w11[i], n);
            tick(1);
        end
        wait_strobes(base, 88, 300);
        tick(4);
        check("t6_count", sbits.size() - base, 88);
        for (int i = 0; i < 11; i++)
            if (sbits.size() - base >= 88)
                check($sformatf("t6_w%0d", i), got_byte(base, i), int'(w11[i]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
